// File: rtl/pool_flatten_pkg.sv
// Shared types and helpers for the pooled-frame flatten buffer: FSM state, sizing
// functions and the shift/round/saturate requantizer applied at write time.
package pool_flatten_pkg;

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  localparam int N_CH = 4;
  localparam int XW   = 64;

  function automatic int cnt_w(input int n_pix);
    return $clog2(n_pix + 1);
  endfunction

  function automatic int total_len(input int n_pix);
    return N_CH * n_pix;
  endfunction

  // One extra bit keeps the rounding add from wrapping at the top of the range.
  function automatic logic signed [XW:0] rq_round(input logic signed [XW-1:0] x, input int q_shift);
    logic signed [XW:0] t;
    t = {x[XW-1], x};
    if (q_shift > 0) t = (t + (65'sd1 <<< (q_shift - 1))) >>> q_shift;
    return t;
  endfunction

  function automatic logic rq_sat(input logic signed [XW-1:0] x, input int q_shift, input int out_w);
    logic signed [XW:0] t;
    logic signed [XW:0] hi;
    t  = rq_round(x, q_shift);
    hi = (65'sd1 <<< (out_w - 1)) - 65'sd1;
    return (t > hi) || (t < (-hi - 65'sd1));
  endfunction

  function automatic logic signed [XW-1:0] rq(input logic signed [XW-1:0] x, input int q_shift, input int out_w);
    logic signed [XW:0] t;
    logic signed [XW:0] hi;
    t  = rq_round(x, q_shift);
    hi = (65'sd1 <<< (out_w - 1)) - 65'sd1;
    if (t > hi) t = hi;
    else if (t < (-hi - 65'sd1)) t = -hi - 65'sd1;
    return XW'(t);
  endfunction

endpackage

// File: rtl/flatten_bank.sv
// One channel's frame store: single write port, registered read port.
// rdata holds its last value while re is low, which the top relies on when stalled.
module flatten_bank #(
  parameter int DEPTH = 39,
  parameter int W     = 8,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pool_flatten_buf.sv
// Captures a 4-channel pooled frame, requantized, then replays it channel-major over valid/ready;
// first output 2 cycles into DRAIN, full rate under iReady; POOL_FLATTEN_SAT_CNT_EN adds oSatCnt.
module pool_flatten_buf
  import pool_flatten_pkg::*;
#(
  parameter int In_d_W  = 32,
  parameter int Out_d_W = 8,
  parameter int N_PIX   = 39,
  parameter int Q_SHIFT = 4
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [3:0]                iValid4,
  input  logic signed [In_d_W-1:0]  iData0,
  input  logic signed [In_d_W-1:0]  iData1,
  input  logic signed [In_d_W-1:0]  iData2,
  input  logic signed [In_d_W-1:0]  iData3,
  output logic                      oValid,
  input  logic                      iReady,
  output logic signed [Out_d_W-1:0] oData,
  output logic                      oLast,
  output logic                      oBusy,
  output logic                      oOvf
`ifdef POOL_FLATTEN_SAT_CNT_EN
  ,
  output logic [15:0]               oSatCnt
`endif
);

  localparam int CW    = cnt_w(N_PIX);
  localparam int TOTAL = total_len(N_PIX);
  localparam int TW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] PIX_FULL = CW'(N_PIX);
  localparam logic [CW-1:0] PIX_LAST = CW'(N_PIX - 1);
  localparam logic [TW-1:0] NUM_ALL  = TW'(TOTAL);
  localparam logic [TW-1:0] NUM_LAST = TW'(TOTAL - 1);

  state_t                   state;
  logic [CW-1:0]            wcnt   [N_CH];
  logic signed [In_d_W-1:0] in_dat [N_CH];
  logic [Out_d_W-1:0]       rq_dat [N_CH];
  logic [Out_d_W-1:0]       rd_dat [N_CH];
  logic [N_CH-1:0]          wr_en, rd_en;
  logic                     all_full;
  logic [1:0]               rd_ch, s1_ch;
  logic [CW-1:0]            rd_pix;
  logic [TW-1:0]            rd_num;
  logic                     s1_vld, s1_last;
  logic                     out_adv, issue, frame_done;

  assign in_dat[0] = iData0;
  assign in_dat[1] = iData1;
  assign in_dat[2] = iData2;
  assign in_dat[3] = iData3;

  // s1 is the bank-output stage; the output register doubles as the skid slot.
  assign out_adv    = !oValid || iReady;
  assign issue      = (state == DRAIN) && (rd_num != NUM_ALL) && (!s1_vld || out_adv);
  assign frame_done = oValid && iReady && oLast;
  assign oBusy      = (state == DRAIN);

  always_comb begin
    all_full = 1'b1;
    wr_en    = '0;
    rd_en    = '0;
    for (int k = 0; k < N_CH; k++) begin
      rq_dat[k] = Out_d_W'(rq(XW'(in_dat[k]), Q_SHIFT, Out_d_W));
      wr_en[k]  = (state == FILL) && iValid4[k] && (wcnt[k] != PIX_FULL);
      rd_en[k]  = issue && (rd_ch == 2'(k));
      all_full &= (wcnt[k] == PIX_FULL);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_bank
    flatten_bank #(.DEPTH(N_PIX), .W(Out_d_W), .AW(CW)) u_bank (
      .clk  (iClk),
      .we   (wr_en[k]),
      .waddr(wcnt[k]),
      .wdata(rq_dat[k]),
      .re   (rd_en[k]),
      .raddr(rd_pix),
      .rdata(rd_dat[k])
    );
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= FILL;
      for (int k = 0; k < N_CH; k++) wcnt[k] <= '0;
      rd_ch   <= '0;
      rd_pix  <= '0;
      rd_num  <= '0;
      s1_vld  <= 1'b0;
      s1_ch   <= '0;
      s1_last <= 1'b0;
      oValid  <= 1'b0;
      oData   <= '0;
      oLast   <= 1'b0;
      oOvf    <= 1'b0;
    end else if (state == FILL) begin
      for (int k = 0; k < N_CH; k++) if (wr_en[k]) wcnt[k] <= wcnt[k] + 1'b1;
      if (|(iValid4 & ~wr_en)) oOvf <= 1'b1;
      if (all_full) state <= DRAIN;
    end else begin
      if (|iValid4) oOvf <= 1'b1;
      if (issue) begin
        s1_ch   <= rd_ch;
        s1_last <= (rd_num == NUM_LAST);
        rd_num  <= rd_num + 1'b1;
        if (rd_pix == PIX_LAST) begin
          rd_pix <= '0;
          rd_ch  <= rd_ch + 1'b1;
        end else begin
          rd_pix <= rd_pix + 1'b1;
        end
      end
      if (!s1_vld || out_adv) s1_vld <= issue;
      if (out_adv) begin
        oValid <= s1_vld;
        oData  <= rd_dat[s1_ch];
        oLast  <= s1_vld && s1_last;
      end
      if (frame_done) begin
        state  <= FILL;
        for (int k = 0; k < N_CH; k++) wcnt[k] <= '0;
        rd_ch  <= '0;
        rd_pix <= '0;
        rd_num <= '0;
        s1_vld <= 1'b0;
        oValid <= 1'b0;
        oLast  <= 1'b0;
      end
    end
  end

`ifdef POOL_FLATTEN_SAT_CNT_EN
  logic [N_CH-1:0] sat_hit;
  logic [16:0]     sat_sum;

  always_comb begin
    sat_hit = '0;
    for (int k = 0; k < N_CH; k++)
      sat_hit[k] = wr_en[k] && rq_sat(XW'(in_dat[k]), Q_SHIFT, Out_d_W);
    sat_sum = {1'b0, oSatCnt} + 17'($countones(sat_hit));
  end

  always_ff @(posedge iClk) begin
    if (iRst || frame_done) oSatCnt <= '0;
    else if (state == FILL) oSatCnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_pool_flatten_buf.sv
// Bench for pool_flatten_buf: frame-level scoreboard plus directed scenarios.
`timescale 1ns/1ps
module tb_pool_flatten_buf;
  localparam int IW = 32, OW = 8, N = 39, Q = 4, TOT = 4 * N;

  logic                 iClk = 1'b0;
  logic                 iRst;
  logic [3:0]           iValid4;
  logic signed [IW-1:0] d [4];
  logic                 oValid, iReady, oLast, oBusy, oOvf;
  logic signed [OW-1:0] oData;
`ifdef POOL_FLATTEN_SAT_CNT_EN
  logic [15:0]          oSatCnt;
`endif

  int checks = 0, errors = 0;
  bit rdy_rand = 1'b0;

  pool_flatten_buf #(.In_d_W(IW), .Out_d_W(OW), .N_PIX(N), .Q_SHIFT(Q)) dut (
    .iClk(iClk), .iRst(iRst), .iValid4(iValid4),
    .iData0(d[0]), .iData1(d[1]), .iData2(d[2]), .iData3(d[3]),
    .oValid(oValid), .iReady(iReady), .oData(oData), .oLast(oLast),
    .oBusy(oBusy), .oOvf(oOvf)
`ifdef POOL_FLATTEN_SAT_CNT_EN
    , .oSatCnt(oSatCnt)
`endif
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Requantization from its arithmetic definition: round half up, then clamp.
  function automatic longint rq_pre(input longint x);
    if (Q > 0) return (x + (longint'(1) <<< (Q - 1))) >>> Q;
    return x;
  endfunction

  function automatic longint rq_m(input longint x);
    longint y, lim;
    y   = rq_pre(x);
    lim = longint'(1) <<< (OW - 1);
    if (y > lim - 1) y = lim - 1;
    if (y < -lim) y = -lim;
    return y;
  endfunction

  function automatic bit rq_is_sat(input longint x);
    longint y, lim;
    y   = rq_pre(x);
    lim = longint'(1) <<< (OW - 1);
    return (y > lim - 1) || (y < -lim);
  endfunction

  // Scoreboard: per-channel captured values, flattened channel-major on replay.
  int  mbank [4][N];
  int  cnt [4];
  bit  m_full, m_ovf, mon_en;
  int  idx, hs_cnt, frames_done, m_sat, bage;
  int  obs [TOT];
  bit  p_stall, p_last, p_busy;
  longint p_dat;

  always @(negedge iClk) begin
    if (mon_en) begin
      chk("ovf_flag", oOvf, m_ovf);
      if (!m_full) chk("busy_before_full", oBusy, 0);
      if (!m_full) chk("valid_without_frame", oValid, 0);
      if (p_stall) begin
        chk("hold_valid", oValid, 1);
        chk("hold_data", oData, p_dat);
        chk("hold_last", oLast, p_last);
      end
      if (oBusy && !p_busy) bage = 0;
      else if (oBusy) bage++;
      if (oBusy && bage <= 2) chk("first_valid_latency", oValid, (bage == 2));
`ifdef POOL_FLATTEN_SAT_CNT_EN
      if (oBusy) chk("sat_cnt", oSatCnt, m_sat);
`endif
      if (iRst) begin
        cnt = '{default:0};
        idx = 0; hs_cnt = 0; m_full = 0; m_ovf = 0; m_sat = 0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (iValid4[k]) begin
            if (cnt[k] < N) begin
              mbank[k][cnt[k]] = int'(rq_m(d[k]));
              if (rq_is_sat(d[k]) && m_sat < 65535) m_sat++;
              cnt[k]++;
            end else begin
              m_ovf = 1;
            end
          end
        end
        if (oValid && iReady && m_full) begin
          chk("data", oData, mbank[idx / N][idx % N]);
          chk("last", oLast, (idx == TOT - 1));
          obs[idx] = oData;
          idx++;
          hs_cnt++;
          if (idx == TOT) begin
            idx = 0; hs_cnt = 0; m_sat = 0;
            cnt = '{default:0};
            frames_done++;
          end
        end
        m_full = (cnt[0] == N) && (cnt[1] == N) && (cnt[2] == N) && (cnt[3] == N);
      end
      p_stall = oValid && !iReady && !iRst;
      p_dat   = oData;
      p_last  = oLast;
      p_busy  = oBusy;
    end
  end

  initial begin
    iReady = 1'b1;
    forever begin
      @(posedge iClk);
      #1 iReady = rdy_rand ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  function automatic int val(input int ft, input int k, input int p);
    if (ft == 1 && k == 0 && p == 0) return 5000;
    if (ft == 1 && k == 0 && p == 1) return -5000;
    if (ft == 1 && k == 0 && p == 2) return 24;
    if (ft == 1 && k == 0 && p == 3) return 23;
    if (ft == 2) return int'($urandom_range(0, 6000)) - 3000;
    return 16 * p + k;
  endfunction

  // Drives one frame; skew adds random gaps and holds ch2's last sample back.
  task automatic drive_frame(input int ft, input bit skew, input bit extra);
    int ptr [4];
    int lag, guard;
    ptr = '{default:0};
    lag = 0;
    guard = 0;
    while ((ptr[0] < N || ptr[1] < N || ptr[2] < N || ptr[3] < N) && guard < 4000) begin
      @(posedge iClk);
      #1;
      for (int k = 0; k < 4; k++) begin
        bit en;
        en = (ptr[k] < N) && (!skew || $urandom_range(0, 9) < 7);
        if (skew && k == 2 && ptr[2] == N - 1 && lag < 10) en = 0;
        iValid4[k] = en;
        d[k] = en ? val(ft, k, ptr[k]) : 0;
        if (en) ptr[k]++;
      end
      if (ptr[0] == N && ptr[1] == N && ptr[3] == N) lag++;
      guard++;
    end
    @(posedge iClk);
    #1;
    iValid4 = extra ? 4'b0001 : 4'b0000;
    d[0] = 999;
    if (extra) begin
      @(posedge iClk);
      #1 iValid4 = 4'b0000;
    end
  endtask

  task automatic wait_busy();
    int g = 0;
    @(negedge iClk);
    while (!oBusy && g < 200) begin @(negedge iClk); g++; end
    chk("busy_rise", oBusy, 1);
  endtask

  task automatic wait_done(input int tgt);
    int g = 0;
    while (frames_done < tgt && g < 3000) begin @(negedge iClk); g++; end
    chk("frame_count", frames_done, tgt);
    @(negedge iClk);
    chk("busy_after_frame", oBusy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    iRst = 1'b1;
    iValid4 = 4'b0000;
    for (int k = 0; k < 4; k++) d[k] = 0;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    chk("reset_valid", oValid, 0);
    chk("reset_busy", oBusy, 0);
    chk("reset_ovf", oOvf, 0);
    chk("reset_last", oLast, 0);
    chk("reset_data", oData, 0);
    mon_en = 1'b1;

    // Known ramp frame
    drive_frame(0, 0, 0);
    wait_done(1);
    chk("ch0_p3", obs[3], 3);
    chk("ch1_p0", obs[N], 0);
    chk("ch2_p10", obs[2 * N + 10], 10);
    chk("ch3_p38", obs[TOT - 1], 38);

    // Rounding and saturation
    drive_frame(1, 0, 0);
    wait_busy();
`ifdef POOL_FLATTEN_SAT_CNT_EN
    @(negedge iClk);
    chk("sat_cnt_two", oSatCnt, 2);
`endif
    wait_done(2);
    chk("sat_pos", obs[0], 127);
    chk("sat_neg", obs[1], -128);
    chk("round_24", obs[2], 2);
    chk("round_23", obs[3], 1);

    // Skewed channels with gaps
    drive_frame(0, 1, 0);
    wait_done(3);
    chk("skew_ch0_p3", obs[3], 3);
    chk("skew_ch3_p38", obs[TOT - 1], 38);

    // Random backpressure with random data
    rdy_rand = 1'b1;
    drive_frame(2, 1, 0);
    wait_done(4);
    rdy_rand = 1'b0;

    // Overflow: 40th ch0 sample in FILL, one input during DRAIN
    drive_frame(0, 0, 1);
    wait_busy();
    @(posedge iClk);
    #1 iValid4 = 4'b0010; d[1] = 77;
    @(posedge iClk);
    #1 iValid4 = 4'b0000;
    @(negedge iClk);
    chk("ovf_set", oOvf, 1);
    wait_done(5);
    drive_frame(0, 0, 0);
    wait_done(6);
    chk("ovf_sticky", oOvf, 1);
    chk("after_ovf_ch0_p3", obs[3], 3);

    // Reset in the middle of DRAIN
    drive_frame(0, 0, 0);
    g = 0;
    while (hs_cnt < 20 && g < 400) begin @(negedge iClk); g++; end
    chk("mid_drain_handshakes", (hs_cnt >= 20), 1);
    @(posedge iClk);
    #1 iRst = 1'b1;
    @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    chk("rst_mid_valid", oValid, 0);
    chk("rst_mid_busy", oBusy, 0);
    chk("rst_mid_ovf", oOvf, 0);
    drive_frame(0, 0, 0);
    wait_done(7);
    chk("fresh_ch0_p3", obs[3], 3);
    chk("fresh_ch3_p38", obs[TOT - 1], 38);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
